// File: rtl/exu_alu_iter.sv
// Integer execute unit: single-cycle ALU ops plus an iterative 1-bit/cycle shifter,
// with valid/ready throttling of the decode stage and a registered writeback port.
module exu_alu_iter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RD_LEN_STA     = 5,
  parameter int unsigned DYN_INST_WIDTH = 4*DATA_WIDTH + RD_LEN_STA + 13
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DYN_INST_WIDTH-1:0] dyn_instr_i,
  input  logic                      dyn_vld_i,
  output logic                      dyn_rdy_o,
  output logic [RD_LEN_STA-1:0]     rd_exeu_o,
  output logic [DATA_WIDTH-1:0]     wrtbck_dat_exeu_o,
  output logic                      wrtbck_en_exeu_o,
  output logic                      busy_o,
  output logic                      invld_err_o
);

  // Decoded-instruction bus layout, LSB first
  localparam int unsigned INVLD_DYNOFF   = 0;
  localparam int unsigned USE_RD_DYNOFF  = 1;
  localparam int unsigned USE_IMM_DYNOFF = 2;
  localparam int unsigned USE_RS2_DYNOFF = 3;
  localparam int unsigned USE_RS1_DYNOFF = 4;
  localparam int unsigned TYPE_DYNOFF    = 5;
  localparam int unsigned ALUOP_DYNOFF   = 9;
  localparam int unsigned RD_DYNOFF      = 13;
  localparam int unsigned PC_DYNOFF      = RD_DYNOFF + RD_LEN_STA;
  localparam int unsigned IMM_DYNOFF     = PC_DYNOFF + DATA_WIDTH;
  localparam int unsigned RS2_DYNOFF     = IMM_DYNOFF + DATA_WIDTH;
  localparam int unsigned RS1_DYNOFF     = RS2_DYNOFF + DATA_WIDTH;

  // Instruction type codes carried in the 4-bit type field
  localparam logic [3:0] U_LUI_INSTR    = 4'd2;
  localparam logic [3:0] U_AUIPC_INSTR  = 4'd3;
  localparam logic [3:0] I_ECALL_INSTR  = 4'd4;
  localparam logic [3:0] I_EBREAK_INSTR = 4'd5;

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WB} state_t;

  state_t                  r_state;
  logic [SHW-1:0]          r_cnt;
  logic [DATA_WIDTH-1:0]   r_sh;
  logic [3:0]              r_op;
  logic [RD_LEN_STA-1:0]   r_rd_pend;
  logic                    r_ok_pend;
  logic [RD_LEN_STA-1:0]   r_rd;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic                    r_en;
  logic                    r_err;

  logic [DATA_WIDTH-1:0]   w_rs1, w_rs2, w_imm, w_pc;
  logic [RD_LEN_STA-1:0]   w_rd;
  logic [3:0]              w_op, w_type;
  logic                    w_use_rs1, w_use_imm, w_use_rd, w_invld;
  logic                    w_unused_rs2;
  logic [DATA_WIDTH-1:0]   w_opa, w_opb, w_res, w_sh_next;
  logic [SHW-1:0]          w_shamt;
  logic                    w_is_shift, w_wb_ok, w_lt, w_ltu;

  assign w_rs1        = dyn_instr_i[RS1_DYNOFF +: DATA_WIDTH];
  assign w_rs2        = dyn_instr_i[RS2_DYNOFF +: DATA_WIDTH];
  assign w_imm        = dyn_instr_i[IMM_DYNOFF +: DATA_WIDTH];
  assign w_pc         = dyn_instr_i[PC_DYNOFF +: DATA_WIDTH];
  assign w_rd         = dyn_instr_i[RD_DYNOFF +: RD_LEN_STA];
  assign w_op         = dyn_instr_i[ALUOP_DYNOFF +: 4];
  assign w_type       = dyn_instr_i[TYPE_DYNOFF +: 4];
  assign w_use_rs1    = dyn_instr_i[USE_RS1_DYNOFF];
  assign w_use_imm    = dyn_instr_i[USE_IMM_DYNOFF];
  assign w_use_rd     = dyn_instr_i[USE_RD_DYNOFF];
  assign w_invld      = dyn_instr_i[INVLD_DYNOFF];
  // Operand B is chosen by use_imm alone, so use_rs2 carries no information here
  assign w_unused_rs2 = dyn_instr_i[USE_RS2_DYNOFF];

  assign w_opa = (w_type == U_AUIPC_INSTR) ? w_pc :
                 (w_type == U_LUI_INSTR)   ? '0   :
                 (w_use_rs1 ? w_rs1 : '0);
  assign w_opb = w_use_imm ? w_imm : w_rs2;

  assign w_shamt    = w_opb[SHW-1:0];
  assign w_is_shift = (w_op == 4'b0001) || (w_op == 4'b0101) || (w_op == 4'b1101);
  assign w_wb_ok    = w_use_rd && (w_rd != '0) && !w_invld &&
                      (w_type != I_ECALL_INSTR) && (w_type != I_EBREAK_INSTR);
  assign w_lt       = $signed(w_opa) < $signed(w_opb);
  assign w_ltu      = w_opa < w_opb;

  // Single-cycle result; shift codes only reach here with a zero shift amount
  always_comb begin
    w_res = w_opa + w_opb;
    case (w_op)
      4'b1000: w_res = w_opa - w_opb;
      4'b0010: w_res = {{(DATA_WIDTH-1){1'b0}}, w_lt};
      4'b0011: w_res = {{(DATA_WIDTH-1){1'b0}}, w_ltu};
      4'b0100: w_res = w_opa ^ w_opb;
      4'b0110: w_res = w_opa | w_opb;
      4'b0111: w_res = w_opa & w_opb;
      4'b0001, 4'b0101, 4'b1101: w_res = w_opa;
      default: w_res = w_opa + w_opb;
    endcase
  end

  // One-bit step of the iterative shifter
  always_comb begin
    w_sh_next = {r_sh[DATA_WIDTH-1], r_sh[DATA_WIDTH-1:1]};
    case (r_op)
      4'b0001: w_sh_next = {r_sh[DATA_WIDTH-2:0], 1'b0};
      4'b0101: w_sh_next = {1'b0, r_sh[DATA_WIDTH-1:1]};
      default: w_sh_next = {r_sh[DATA_WIDTH-1], r_sh[DATA_WIDTH-1:1]};
    endcase
  end

  // Control FSM, shifter state and writeback registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sh      <= '0;
      r_op      <= '0;
      r_rd_pend <= '0;
      r_ok_pend <= 1'b0;
      r_rd      <= '0;
      r_dat     <= '0;
      r_en      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (dyn_vld_i) begin
            if (w_invld) r_err <= 1'b1;
            if (w_is_shift && (w_shamt != '0)) begin
              r_sh      <= w_opa;
              r_cnt     <= w_shamt;
              r_op      <= w_op;
              r_rd_pend <= w_rd;
              r_ok_pend <= w_wb_ok;
              r_state   <= ST_SHIFT;
            end else begin
              r_dat   <= w_res;
              r_rd    <= w_rd;
              r_en    <= w_wb_ok;
              r_state <= ST_WB;
            end
          end
        end
        ST_SHIFT: begin
          r_sh  <= w_sh_next;
          r_cnt <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_dat   <= w_sh_next;
            r_rd    <= r_rd_pend;
            r_en    <= r_ok_pend;
            r_state <= ST_WB;
          end
        end
        ST_WB:   r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dyn_rdy_o         = (r_state == ST_IDLE);
  assign busy_o            = (r_state != ST_IDLE);
  assign rd_exeu_o         = r_rd;
  assign wrtbck_dat_exeu_o = r_dat;
  assign wrtbck_en_exeu_o  = r_en;
  assign invld_err_o       = r_err;

endmodule

// File: tb/tb_exu_alu_iter.sv
// Bench for exu_alu_iter: directed vectors with hand-computed results, plus a
// cycle-timed reference model compared against the DUT on every cycle.
module tb_exu_alu_iter;

  localparam int DW  = 32;
  localparam int RDW = 5;
  localparam int IW  = 4*DW + RDW + 13;

  localparam int INVLD_OFF = 0, USE_RD_OFF = 1, USE_IMM_OFF = 2, USE_RS2_OFF = 3, USE_RS1_OFF = 4;
  localparam int TYPE_OFF = 5, OP_OFF = 9, RD_OFF = 13, PC_OFF = 18, IMM_OFF = 50, RS2_OFF = 82, RS1_OFF = 114;

  localparam logic [3:0] T_RCOMP = 4'd0, T_ICOMP = 4'd1, T_LUI = 4'd2, T_AUIPC = 4'd3,
                         T_ECALL = 4'd4, T_EBREAK = 4'd5;
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SLL = 4'b0001, OP_SLT = 4'b0010, OP_SLTU = 4'b0011,
                         OP_XOR = 4'b0100, OP_SRL = 4'b0101, OP_OR = 4'b0110, OP_AND = 4'b0111,
                         OP_SUB = 4'b1000, OP_SRA = 4'b1101;

  logic           clk;
  logic           rst_n;
  logic [IW-1:0]  dyn_instr_i;
  logic           dyn_vld_i;
  logic           dyn_rdy_o;
  logic [RDW-1:0] rd_exeu_o;
  logic [DW-1:0]  wrtbck_dat_exeu_o;
  logic           wrtbck_en_exeu_o;
  logic           busy_o;
  logic           invld_err_o;

  exu_alu_iter #(.DATA_WIDTH(DW), .RD_LEN_STA(RDW), .DYN_INST_WIDTH(IW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dyn_instr_i       (dyn_instr_i),
    .dyn_vld_i         (dyn_vld_i),
    .dyn_rdy_o         (dyn_rdy_o),
    .rd_exeu_o         (rd_exeu_o),
    .wrtbck_dat_exeu_o (wrtbck_dat_exeu_o),
    .wrtbck_en_exeu_o  (wrtbck_en_exeu_o),
    .busy_o            (busy_o),
    .invld_err_o       (invld_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [31:0] imm, input logic [31:0] pc,
                                       input logic [4:0] rd, input logic [3:0] op,
                                       input logic [3:0] typ, input logic u1, input logic u2,
                                       input logic ui, input logic urd, input logic inv);
    logic [IW-1:0] x;
    x = '0;
    x[RS1_OFF +: 32] = rs1;
    x[RS2_OFF +: 32] = rs2;
    x[IMM_OFF +: 32] = imm;
    x[PC_OFF  +: 32] = pc;
    x[RD_OFF  +: 5]  = rd;
    x[OP_OFF  +: 4]  = op;
    x[TYPE_OFF +: 4] = typ;
    x[USE_RS1_OFF]   = u1;
    x[USE_RS2_OFF]   = u2;
    x[USE_IMM_OFF]   = ui;
    x[USE_RD_OFF]    = urd;
    x[INVLD_OFF]     = inv;
    return x;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] f_opa(input logic [IW-1:0] x);
    if (x[TYPE_OFF +: 4] == T_AUIPC) return x[PC_OFF +: 32];
    if (x[TYPE_OFF +: 4] == T_LUI) return 32'd0;
    return x[USE_RS1_OFF] ? x[RS1_OFF +: 32] : 32'd0;
  endfunction

  function automatic logic [31:0] f_opb(input logic [IW-1:0] x);
    return x[USE_IMM_OFF] ? x[IMM_OFF +: 32] : x[RS2_OFF +: 32];
  endfunction

  function automatic logic [31:0] f_result(input logic [IW-1:0] x);
    logic [31:0] a, b;
    a = f_opa(x);
    b = f_opb(x);
    case (x[OP_OFF +: 4])
      OP_SUB:  return a - b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return 32'($signed(a) >>> b[4:0]);
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      default: return a + b;
    endcase
  endfunction

  function automatic int f_lat(input logic [IW-1:0] x);
    logic [31:0] b;
    b = f_opb(x);
    if (x[OP_OFF +: 4] == OP_SLL || x[OP_OFF +: 4] == OP_SRL || x[OP_OFF +: 4] == OP_SRA)
      return int'(b[4:0]);
    return 0;
  endfunction

  function automatic logic f_ok(input logic [IW-1:0] x);
    return x[USE_RD_OFF] && (x[RD_OFF +: 5] != 5'd0) && !x[INVLD_OFF] &&
           (x[TYPE_OFF +: 4] != T_ECALL) && (x[TYPE_OFF +: 4] != T_EBREAK);
  endfunction

  // Model timeline: m_edge counts clock edges; an instruction accepted at the edge
  // that makes m_edge=E0 writes back in cycle E0+L and frees the unit from E0+L+1.
  int          m_edge, m_rdy_from, m_wb_cycle;
  logic        m_ok, m_err;
  logic [31:0] m_cur_dat, m_pend_dat;
  logic [4:0]  m_cur_rd, m_pend_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge     <= 0;
      m_rdy_from <= 0;
      m_wb_cycle <= -1;
      m_ok       <= 1'b0;
      m_err      <= 1'b0;
      m_cur_dat  <= '0;
      m_pend_dat <= '0;
      m_cur_rd   <= '0;
      m_pend_rd  <= '0;
    end else begin
      m_edge <= m_edge + 1;
      if (m_edge + 1 == m_wb_cycle) begin
        m_cur_dat <= m_pend_dat;
        m_cur_rd  <= m_pend_rd;
      end
      if (dyn_vld_i && (m_edge >= m_rdy_from)) begin
        m_wb_cycle <= m_edge + 1 + f_lat(dyn_instr_i);
        m_rdy_from <= m_edge + 2 + f_lat(dyn_instr_i);
        m_pend_dat <= f_result(dyn_instr_i);
        m_pend_rd  <= dyn_instr_i[RD_OFF +: 5];
        m_ok       <= f_ok(dyn_instr_i);
        if (dyn_instr_i[INVLD_OFF]) m_err <= 1'b1;
        if (f_lat(dyn_instr_i) == 0) begin
          m_cur_dat <= f_result(dyn_instr_i);
          m_cur_rd  <= dyn_instr_i[RD_OFF +: 5];
        end
      end
    end
  end

  logic chk_en = 1'b0;

  // Every-cycle comparison of DUT against the model, on the falling edge
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("cyc_rdy",   32'(dyn_rdy_o),         32'(m_edge >= m_rdy_from));
      chk("cyc_busy",  32'(busy_o),            32'(m_edge < m_rdy_from));
      chk("cyc_en",    32'(wrtbck_en_exeu_o),  32'((m_edge == m_wb_cycle) && m_ok));
      chk("cyc_dat",   wrtbck_dat_exeu_o,      m_cur_dat);
      chk("cyc_rd",    32'(rd_exeu_o),         32'(m_cur_rd));
      chk("cyc_err",   32'(invld_err_o),       32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [IW-1:0] x);
    int n;
    dyn_instr_i = x;
    dyn_vld_i   = 1'b1;
    n = 0;
    while (!dyn_rdy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: dyn_rdy_o stayed 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    @(negedge clk);
    dyn_vld_i = 1'b0;
    for (int k = 0; k < IW; k++) dyn_instr_i[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic measure(output int en_at, output int low);
    en_at = -1;
    low   = 0;
    for (int i = 0; i < 100; i++) begin
      if (wrtbck_en_exeu_o && en_at < 0) en_at = i;
      if (dyn_rdy_o) return;
      low++;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL measure_timeout: dyn_rdy_o low for %0d cycles, expected return to 1", low);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rdy"},  32'(dyn_rdy_o),        32'd1);
    chk({tag, "_en"},   32'(wrtbck_en_exeu_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o),           32'd0);
    chk({tag, "_dat"},  wrtbck_dat_exeu_o,     32'd0);
    chk({tag, "_rd"},   32'(rd_exeu_o),        32'd0);
    chk({tag, "_err"},  32'(invld_err_o),      32'd0);
  endtask

  typedef struct {
    logic [IW-1:0] ins;
    logic [31:0]   dat;
    logic [4:0]    rd;
    int            en_at;
    int            low;
  } vec_t;

  vec_t vt[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_at, low, first, second, pulses;
    logic [31:0] d1, d2;
    logic seen_inv;

    rst_n       = 1'b0;
    dyn_vld_i   = 1'b0;
    dyn_instr_i = '0;
    seen_inv    = 1'b0;

    // name-ordered: instr, data, rd, en cycle after E0 (-1 = suppressed), rdy-low cycles
    vt.push_back('{mk(32'h7FFFFFFF, 0, 32'd1, 0, 5'd5, OP_ADD, T_ICOMP, 1, 0, 1, 1, 0), 32'h80000000, 5'd5, 0, 1});
    vt.push_back('{mk(32'h80000000, 0, 32'd31, 0, 5'd3, OP_SRA, T_ICOMP, 1, 0, 1, 1, 0), 32'hFFFFFFFF, 5'd3, 31, 32});
    vt.push_back('{mk(32'h80000000, 0, 32'd0, 0, 5'd3, OP_SRA, T_ICOMP, 1, 0, 1, 1, 0), 32'h80000000, 5'd3, 0, 1});
    vt.push_back('{mk(0, 0, 32'h00001000, 32'h80000004, 5'd4, OP_ADD, T_AUIPC, 0, 0, 1, 1, 0), 32'h80001004, 5'd4, 0, 1});
    vt.push_back('{mk(32'hFFFFFFFF, 0, 32'h12345000, 0, 5'd6, OP_ADD, T_LUI, 1, 0, 1, 1, 0), 32'h12345000, 5'd6, 0, 1});
    vt.push_back('{mk(32'd5, 32'd7, 0, 0, 5'd8, OP_SUB, T_RCOMP, 1, 1, 0, 1, 0), 32'hFFFFFFFE, 5'd8, 0, 1});
    vt.push_back('{mk(32'hF0F00000, 0, 32'h0000F0F0, 0, 5'd10, OP_OR, T_ICOMP, 1, 0, 1, 1, 0), 32'hF0F0F0F0, 5'd10, 0, 1});
    vt.push_back('{mk(32'hFFFF0000, 32'h0FF00FF0, 0, 0, 5'd11, OP_AND, T_RCOMP, 1, 1, 0, 1, 0), 32'h0FF00000, 5'd11, 0, 1});
    vt.push_back('{mk(32'h80000000, 32'hFFFFFFE8, 0, 0, 5'd12, OP_SRL, T_RCOMP, 1, 1, 0, 1, 0), 32'h00800000, 5'd12, 8, 9});
    vt.push_back('{mk(32'd3, 0, 32'h21, 0, 5'd13, OP_SLL, T_ICOMP, 1, 0, 1, 1, 0), 32'd6, 5'd13, 1, 2});
    vt.push_back('{mk(32'h10, 0, 32'h20, 0, 5'd14, 4'b1111, T_ICOMP, 1, 0, 1, 1, 0), 32'h30, 5'd14, 0, 1});
    vt.push_back('{mk(32'd1, 32'hFFFFFFFF, 0, 0, 5'd15, OP_SLTU, T_RCOMP, 1, 1, 0, 1, 0), 32'd1, 5'd15, 0, 1});
    vt.push_back('{mk(32'd1, 32'hFFFFFFFF, 0, 0, 5'd16, OP_SLT, T_RCOMP, 1, 1, 0, 1, 0), 32'd0, 5'd16, 0, 1});
    vt.push_back('{mk(0, 0, 0, 0, 5'd1, OP_ADD, T_ECALL, 0, 0, 1, 1, 0), 32'd0, 5'd1, -1, 1});
    vt.push_back('{mk(32'd2, 0, 32'd3, 0, 5'd7, OP_ADD, T_ICOMP, 1, 0, 1, 1, 1), 32'd5, 5'd7, -1, 1});
    vt.push_back('{mk(32'd9, 0, 32'd1, 0, 5'd0, OP_ADD, T_ICOMP, 1, 0, 1, 1, 0), 32'hA, 5'd0, -1, 1});
    vt.push_back('{mk(32'd9, 0, 32'd2, 0, 5'd17, OP_ADD, T_ICOMP, 1, 0, 1, 0, 0), 32'hB, 5'd17, -1, 1});
    vt.push_back('{mk(32'hFFFFFFFF, 0, 32'd4, 0, 5'd18, OP_ADD, T_ICOMP, 0, 0, 1, 1, 0), 32'd4, 5'd18, 0, 1});
    vt.push_back('{mk(32'h80000010, 32'd4, 0, 0, 5'd19, OP_SRA, T_RCOMP, 1, 1, 0, 1, 0), 32'hF8000001, 5'd19, 4, 5});

    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check_reset("post_reset");
    chk_en = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      send(vt[i].ins);
      if (vt[i].ins[INVLD_OFF]) seen_inv = 1'b1;
      chk($sformatf("v%0d_err_at_e0", i), 32'(invld_err_o), 32'(seen_inv));
      measure(en_at, low);
      chk($sformatf("v%0d_en_cycle", i), 32'(en_at), 32'(vt[i].en_at));
      chk($sformatf("v%0d_rdy_low", i),  32'(low),   32'(vt[i].low));
      chk($sformatf("v%0d_dat", i),      wrtbck_dat_exeu_o, vt[i].dat);
      chk($sformatf("v%0d_rd", i),       32'(rd_exeu_o),    32'(vt[i].rd));
    end

    // Back-to-back with valid held high: SLL by 4 then XOR
    dyn_instr_i = mk(32'h000000F1, 0, 32'd4, 0, 5'd20, OP_SLL, T_ICOMP, 1, 0, 1, 1, 0);
    dyn_vld_i   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dyn_instr_i = mk(32'hFF00FF00, 32'h0F0F0F0F, 0, 0, 5'd21, OP_XOR, T_RCOMP, 1, 1, 0, 1, 0);
    first = -1; second = -1; d1 = '0; d2 = '0;
    for (int i = 0; i < 20; i++) begin
      if (wrtbck_en_exeu_o) begin
        if (first < 0) begin
          first = i; d1 = wrtbck_dat_exeu_o;
        end else if (second < 0) begin
          second = i; d2 = wrtbck_dat_exeu_o;
        end
      end
      if (i == 6) dyn_vld_i = 1'b0;
      @(negedge clk);
    end
    chk("b2b_sll_cycle", 32'(first),  32'd4);
    chk("b2b_sll_dat",   d1,          32'h00000F10);
    chk("b2b_xor_cycle", 32'(second), 32'd6);
    chk("b2b_xor_dat",   d2,          32'hF00FF00F);

    // Asynchronous reset in the middle of a 10-step shift
    send(mk(32'd1, 0, 32'd10, 0, 5'd9, OP_SLL, T_ICOMP, 1, 0, 1, 1, 0));
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", 32'(busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (wrtbck_en_exeu_o) pulses++;
    end
    chk("abort_no_wb",   32'(pulses),            32'd0);
    chk("abort_idle",    32'(dyn_rdy_o),         32'd1);
    chk("abort_dat",     wrtbck_dat_exeu_o,      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
